video_frame_stats: RTL and testbench
====================================

Name: video_frame_stats

Overview:
Inline AXI4-Stream video stage placed directly downstream of the gamma corrector. Passes the video stream through unchanged with one register stage. Measures each frame as it passes: active width, height, pixel sum, minimum and maximum of component 0. Publishes these values with a one-cycle valid pulse, so software and auto-exposure logic can observe post-gamma statistics.

Parameters:
PX_WIDTH, 10, bits per colour component; statistics use video_i_tdata[PX_WIDTH-1:0]
TDATA_WIDTH, 32, stream data width (>= PX_WIDTH)
CNT_WIDTH, 12, width of the pixel-per-line and line-per-frame counters
SUM_WIDTH (localparam), PX_WIDTH+2*CNT_WIDTH, pixel accumulator width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
video_i_tdata  in  TDATA_WIDTH  input pixel
video_i_tvalid  in  1  input valid
video_i_tlast  in  1  end of line
video_i_tuser  in  1  start of frame
video_i_tready  out  1  input ready
video_o_tdata  out  TDATA_WIDTH  registered pixel
video_o_tvalid  out  1  output valid
video_o_tlast  out  1  registered tlast
video_o_tuser  out  1  registered tuser
video_o_tready  in  1  downstream ready
stats_valid_o  out  1  one-cycle pulse: stats outputs updated
frame_width_o  out  CNT_WIDTH  pixels in the first line of the last frame
frame_height_o  out  CNT_WIDTH  completed lines in the last frame
px_sum_o  out  SUM_WIDTH  sum of component 0 over the last frame
px_min_o  out  PX_WIDTH  minimum component 0
px_max_o  out  PX_WIDTH  maximum component 0
frame_err_o  out  1  last frame had ragged or partial lines
frame_cnt_o  out  16  count of frames reported, wraps at 0xFFFF->0

Behaviour:
- Reset is synchronous and active-low: rst_n_i=0 sampled at a clk_i edge.
- Reset values: all outputs 0, except video_i_tready, which is 1 once the output register is empty. FSM enters WAIT_SOF.
- Passthrough is a single register slice:
  - video_i_tready = !video_o_tvalid || video_o_tready.
  - On an input handshake, tdata/tlast/tuser load into the output register and video_o_tvalid is set.
  - video_o_tvalid clears on an output handshake with no new input.
  - Latency is 1 cycle. Output is stable while tvalid=1 and tready=0. Back-to-back throughput is 1 beat/cycle.
- Statistics update only on an input handshake (beat = tvalid && tready).
- FSM WAIT_SOF:
  - Beats with tuser=0 are passed through but ignored for statistics.
  - A beat with tuser=1 starts a frame: px_cnt=1, line_cnt=0, width_ref=0, sum=px, min=max=px, err=0. Go to IN_FRAME.
- FSM IN_FRAME, beat with tuser=0:
  - px_cnt++, sum+=px, min/max updated.
  - If tlast: line_cnt++, px_cnt=0.
  - If width_ref==0, width_ref=px_cnt+1 (line length including this beat).
  - Else if width_ref != px_cnt+1, err=1.
- FSM IN_FRAME, beat with tuser=1 (next SOF) closes the frame:
  - If line_cnt>0: latch frame_width_o=width_ref, frame_height_o=line_cnt, px_sum/min/max and frame_err_o. frame_err_o is err, or-ed with (px_cnt!=0), i.e. a partial trailing line.
  - On that latch, pulse stats_valid_o high for exactly the next cycle and increment frame_cnt_o.
  - If line_cnt==0, nothing is reported.
  - In both cases the new frame starts on the same beat, as in WAIT_SOF.
- A tuser=1 beat that also has tlast=1 counts as a one-pixel line of the new frame.
- Stats outputs hold their values between pulses.
- Pixel sums include pixels of partial lines.
- Counters saturate at all-ones and never wrap. A saturated px_cnt or line_cnt sets err.
- Reset mid-frame: the frame is discarded, no stats pulse, FSM returns to WAIT_SOF, and any pending output beat is dropped.
- An input beat arriving while the output is stalled is not accepted, so stats never count an unaccepted beat.

Test Plan:
- Frame 4x3 with pixel value = index 0..11, SOF, then SOF of the next frame -> stats_valid_o pulses once; width=4, height=3, sum=66, min=0, max=11, err=0, frame_cnt=1.
- Same frame with video_o_tready toggling 1,0,0,1 -> output beats are identical in order and value to input; no beat lost or duplicated; stats unchanged from the previous case.
- Line lengths 4,3,4 -> width=4, height=3, err=1.
- Frame ends with 2 pixels after the last tlast -> height counts only full lines; sum includes the extra pixels; err=1.
- 5 beats with tuser=0 after reset, then frame 2x2 of values {1023,5,7,9}, then SOF -> leading beats are passed but not counted; min=5, max=1023, sum=1044.
- rst_n_i=0 for one cycle in mid-frame, then 2x2 frame and SOF -> no pulse from the aborted frame; first pulse reports 2x2 with frame_cnt=1.

Source files
------------

// File: rtl/video_frame_stats.sv
// Inline AXI4-Stream register slice that also measures each passing frame:
// width, height, component-0 sum/min/max and a ragged-line error flag.
module video_frame_stats #(
   parameter  int PX_WIDTH    = 10,
   parameter  int TDATA_WIDTH = 32,
   parameter  int CNT_WIDTH   = 12,
   localparam int SUM_WIDTH   = PX_WIDTH + 2*CNT_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [TDATA_WIDTH-1:0] video_i_tdata,
   input  logic                   video_i_tvalid,
   input  logic                   video_i_tlast,
   input  logic                   video_i_tuser,
   output logic                   video_i_tready,
   output logic [TDATA_WIDTH-1:0] video_o_tdata,
   output logic                   video_o_tvalid,
   output logic                   video_o_tlast,
   output logic                   video_o_tuser,
   input  logic                   video_o_tready,
   output logic                   stats_valid_o,
   output logic [CNT_WIDTH-1:0]   frame_width_o,
   output logic [CNT_WIDTH-1:0]   frame_height_o,
   output logic [SUM_WIDTH-1:0]   px_sum_o,
   output logic [PX_WIDTH-1:0]    px_min_o,
   output logic [PX_WIDTH-1:0]    px_max_o,
   output logic                   frame_err_o,
   output logic [15:0]            frame_cnt_o
);

   typedef enum logic {WAIT_SOF, IN_FRAME} state_t;

   state_t                 state_q;
   logic [TDATA_WIDTH-1:0] data_q;
   logic                   vld_q, last_q, user_q;
   logic [CNT_WIDTH-1:0]   px_cnt_q, line_cnt_q, width_ref_q;
   logic [SUM_WIDTH-1:0]   sum_q;
   logic [PX_WIDTH-1:0]    min_q, max_q;
   logic                   err_q;

   logic                   stats_vld_q, frame_err_q;
   logic [CNT_WIDTH-1:0]   frame_width_q, frame_height_q;
   logic [SUM_WIDTH-1:0]   px_sum_q;
   logic [PX_WIDTH-1:0]    px_min_q, px_max_q;
   logic [15:0]            frame_cnt_q;

   logic                   beat;
   logic [PX_WIDTH-1:0]    px;
   logic                   px_sat, line_sat;
   logic [CNT_WIDTH-1:0]   px_inc_d, line_inc_d;
   logic [SUM_WIDTH:0]     sum_ext;
   logic [SUM_WIDTH-1:0]   sum_d;

   assign video_i_tready = !vld_q || video_o_tready;
   assign beat           = video_i_tvalid && video_i_tready;
   assign px             = video_i_tdata[PX_WIDTH-1:0];

   // Counters and the accumulator stick at all-ones instead of wrapping.
   always_comb begin
      px_sat     = &px_cnt_q;
      line_sat   = &line_cnt_q;
      px_inc_d   = px_sat   ? px_cnt_q   : px_cnt_q + 1'b1;
      line_inc_d = line_sat ? line_cnt_q : line_cnt_q + 1'b1;
      sum_ext    = {1'b0, sum_q} + {{(SUM_WIDTH+1-PX_WIDTH){1'b0}}, px};
      sum_d      = sum_ext[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : sum_ext[SUM_WIDTH-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q        <= WAIT_SOF;
         data_q         <= '0;
         vld_q          <= 1'b0;
         last_q         <= 1'b0;
         user_q         <= 1'b0;
         px_cnt_q       <= '0;
         line_cnt_q     <= '0;
         width_ref_q    <= '0;
         sum_q          <= '0;
         min_q          <= '0;
         max_q          <= '0;
         err_q          <= 1'b0;
         stats_vld_q    <= 1'b0;
         frame_err_q    <= 1'b0;
         frame_width_q  <= '0;
         frame_height_q <= '0;
         px_sum_q       <= '0;
         px_min_q       <= '0;
         px_max_q       <= '0;
         frame_cnt_q    <= '0;
      end else begin
         stats_vld_q <= 1'b0;
         if (video_i_tready) begin
            vld_q <= video_i_tvalid;
            if (video_i_tvalid) begin
               data_q <= video_i_tdata;
               last_q <= video_i_tlast;
               user_q <= video_i_tuser;
            end
         end

         if (beat) begin
            if (video_i_tuser) begin
               if (state_q == IN_FRAME && line_cnt_q != '0) begin
                  frame_width_q  <= width_ref_q;
                  frame_height_q <= line_cnt_q;
                  px_sum_q       <= sum_q;
                  px_min_q       <= min_q;
                  px_max_q       <= max_q;
                  frame_err_q    <= err_q || (px_cnt_q != '0);
                  stats_vld_q    <= 1'b1;
                  frame_cnt_q    <= frame_cnt_q + 16'd1;
               end
               // SOF with tlast is a complete one-pixel first line.
               state_q     <= IN_FRAME;
               px_cnt_q    <= video_i_tlast ? CNT_WIDTH'(0) : CNT_WIDTH'(1);
               line_cnt_q  <= video_i_tlast ? CNT_WIDTH'(1) : CNT_WIDTH'(0);
               width_ref_q <= video_i_tlast ? CNT_WIDTH'(1) : CNT_WIDTH'(0);
               sum_q       <= {{(SUM_WIDTH-PX_WIDTH){1'b0}}, px};
               min_q       <= px;
               max_q       <= px;
               err_q       <= 1'b0;
            end else if (state_q == IN_FRAME) begin
               sum_q <= sum_d;
               if (px < min_q) min_q <= px;
               if (px > max_q) max_q <= px;
               if (px_sat) err_q <= 1'b1;
               if (video_i_tlast) begin
                  px_cnt_q   <= '0;
                  line_cnt_q <= line_inc_d;
                  if (line_sat) err_q <= 1'b1;
                  if (width_ref_q == '0)
                     width_ref_q <= px_inc_d;
                  else if (width_ref_q != px_inc_d)
                     err_q <= 1'b1;
               end else begin
                  px_cnt_q <= px_inc_d;
               end
            end
         end
      end
   end

   assign video_o_tdata  = data_q;
   assign video_o_tvalid = vld_q;
   assign video_o_tlast  = last_q;
   assign video_o_tuser  = user_q;
   assign stats_valid_o  = stats_vld_q;
   assign frame_width_o  = frame_width_q;
   assign frame_height_o = frame_height_q;
   assign px_sum_o       = px_sum_q;
   assign px_min_o       = px_min_q;
   assign px_max_o       = px_max_q;
   assign frame_err_o    = frame_err_q;
   assign frame_cnt_o    = frame_cnt_q;

endmodule

// File: tb/tb_video_frame_stats.sv
// Directed bench for video_frame_stats: passthrough scoreboard plus
// hand-computed per-frame statistics.
module tb_video_frame_stats;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] vi_data;
   logic        vi_valid, vi_last, vi_user, vi_ready;
   logic [31:0] vo_data;
   logic        vo_valid, vo_last, vo_user;
   logic        vo_ready = 1'b1;
   logic        stats_valid, frame_err;
   logic [11:0] frame_width, frame_height;
   logic [33:0] px_sum;
   logic [9:0]  px_min, px_max;
   logic [15:0] frame_cnt;

   int          n_chk = 0;
   int          n_fail = 0;
   int          pulse_cnt = 0;
   int          pbase = 0;
   int          cyc = 0;
   bit          rdy_mode = 1'b0;
   logic [3:0]  pat = 4'b1001;
   logic [33:0] expq[$];

   video_frame_stats dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .video_i_tdata(vi_data), .video_i_tvalid(vi_valid),
      .video_i_tlast(vi_last), .video_i_tuser(vi_user), .video_i_tready(vi_ready),
      .video_o_tdata(vo_data), .video_o_tvalid(vo_valid),
      .video_o_tlast(vo_last), .video_o_tuser(vo_user), .video_o_tready(vo_ready),
      .stats_valid_o(stats_valid), .frame_width_o(frame_width),
      .frame_height_o(frame_height), .px_sum_o(px_sum), .px_min_o(px_min),
      .px_max_o(px_max), .frame_err_o(frame_err), .frame_cnt_o(frame_cnt)
   );

   always #5 clk = ~clk;

   // Downstream ready changes just after posedge: always 1, or pattern 1,0,0,1.
   always @(posedge clk) begin
      #1;
      cyc++;
      vo_ready = rdy_mode ? pat[cyc % 4] : 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Handshakes are decided at the coming posedge; values are stable here.
   always @(negedge clk) begin
      if (rst_n && stats_valid) pulse_cnt++;
      if (rst_n && vo_valid && vo_ready) begin
         if (expq.size() == 0) chk("extra_out_beat", 1, 0);
         else begin
            logic [33:0] e;
            e = expq.pop_front();
            chk("out_data", vo_data, e[31:0]);
            chk("out_user", vo_user, e[32]);
            chk("out_last", vo_last, e[33]);
         end
      end
   end

   task automatic beat(input int d, input bit l, input bit u);
      int g;
      vi_data = d; vi_last = l; vi_user = u; vi_valid = 1'b1;
      g = 0;
      while (!vi_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) chk("tready_timeout", vi_ready, 1);
      expq.push_back({l, u, d[31:0]});
      @(negedge clk);
      vi_valid = 1'b0;
   endtask

   task automatic line(input int start, input int len, input bit sof);
      for (int i = 0; i < len; i++) beat(start + i, i == len - 1, sof && i == 0);
   endtask

   task automatic idle(input int n);
      vi_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_stats(input int w, input int h, input int s, input int mn,
                            input int mx, input int er, input int cnt, input int pulses);
      chk("width", frame_width, w);
      chk("height", frame_height, h);
      chk("sum", px_sum, s);
      chk("min", px_min, mn);
      chk("max", px_max, mx);
      chk("err", frame_err, er);
      chk("frame_cnt", frame_cnt, cnt);
      chk("pulses", pulse_cnt - pbase, pulses);
   endtask

   task automatic chk_reset();
      chk("rst_tready", vi_ready, 1);
      chk("rst_ovalid", vo_valid, 0);
      chk("rst_stats_valid", stats_valid, 0);
      chk("rst_width", frame_width, 0);
      chk("rst_sum", px_sum, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
   endtask

   initial begin
      rst_n = 1'b0; vi_data = '0; vi_valid = 1'b0; vi_last = 1'b0; vi_user = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset();
      rst_n = 1'b1;

      // 4x3 frame of 0..11, then the same frame under output back-pressure.
      line(0, 4, 1); line(4, 4, 0); line(8, 4, 0);
      rdy_mode = 1'b1;
      line(0, 4, 1); line(4, 4, 0); line(8, 4, 0);
      idle(8);
      chk_stats(4, 3, 66, 0, 11, 0, 1, 1);
      rdy_mode = 1'b0;
      idle(2);

      // Ragged lines 4,3,4 (values 0..10).
      line(0, 4, 1);
      chk_stats(4, 3, 66, 0, 11, 0, 2, 2);
      line(4, 3, 0); line(7, 4, 0);

      // Two full lines plus a 2-pixel trailing fragment.
      line(0, 4, 1);
      chk_stats(4, 3, 55, 0, 10, 1, 3, 3);
      line(4, 4, 0);
      beat(8, 0, 0); beat(9, 0, 0);
      beat(0, 0, 1);
      idle(3);
      chk_stats(4, 2, 45, 0, 9, 1, 4, 4);

      // Reset, leading non-SOF beats, then 2x2 {1023,5,7,9}.
      idle(2);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset();
      rst_n = 1'b1;
      pbase = pulse_cnt;
      repeat (4) beat(500, 0, 0);
      beat(500, 1, 0);
      beat(1023, 0, 1); beat(5, 1, 0); beat(7, 0, 0); beat(9, 1, 0);
      beat(0, 0, 1);
      idle(3);
      chk_stats(2, 2, 1044, 5, 1023, 0, 1, 1);

      // Reset in the middle of a frame with one completed line.
      beat(3, 0, 1); beat(4, 1, 0); beat(6, 0, 0);
      idle(2);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      pbase = pulse_cnt;
      beat(2, 0, 1); beat(4, 1, 0); beat(6, 0, 0); beat(8, 1, 0);
      beat(1, 0, 1);
      idle(4);
      chk_stats(2, 2, 20, 2, 8, 0, 1, 1);
      chk("outq_drained", expq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
